link_tx_arbiter: RTL and testbench
==================================

Name: link_tx_arbiter

Overview:
- Shares one serial transmit line among N byte requesters using round-robin arbitration.
- Serializes the granted byte in the same frame format the link receive path expects: start 0, 8 data bits LSB first, parity bit, stop 1.
- Sits at the transmit end of the serial link. Its tx output drives the link input of the receive/decode path.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- CLKS_PER_BIT, 1, clock cycles each serial bit is held on tx; legal range ≥1.
- PARITY_ODD, 1, 1 = odd parity (data plus parity bit has an odd number of ones); 0 = even parity.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- arst  in  1  reset; synchronous, active-high.
- req  in  N  per-requester transmit request; level, held until that requester's grant.
- req_data  in  N*8  byte for requester i is req_data[8i+7:8i]; held stable while req[i] is high.
- grant  out  N  one-hot, one-cycle pulse; that requester's byte is captured this cycle.
- tx  out  1  registered serial line; idles high.
- busy  out  1  high from the cycle after grant until the last stop-bit cycle, inclusive.
- owner  out  $clog2(N)  index of the requester currently being sent; holds its last value when idle.

Behaviour:
- Reset (arst=1 at an edge):
  - Next cycle: state=IDLE, tx=1, grant=0, busy=0, owner=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - Bit counter and clock divider cleared.
  - Reset mid-frame aborts the frame: tx is 1 the following cycle and the partial frame is discarded.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If any req bit is set, choose the first requester at or after the pointer, wrapping N-1 to 0.
  - In the same cycle: assert grant for that requester, latch its byte into the shift register, compute parity, load owner.
  - Next state is START.
  - The pointer advances to (winner+1) mod N.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0, for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - After 8 bits, go to PARITY.
- PARITY:
  - tx = ^byte XOR PARITY_ODD, held for CLKS_PER_BIT cycles.
  - Then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Grant cycle = G. The start bit appears on tx from edge G+1.
  - A frame is 11*CLKS_PER_BIT cycles. The minimum grant-to-grant spacing is 11*CLKS_PER_BIT+1 cycles.
  - The IDLE grant cycle is the mandatory inter-frame idle (tx=1).
- Requests arriving while busy are not granted. They wait, and no request is lost if held.
- req[i] dropped before its grant: no effect and no pointer change.
- req[i] dropped after its grant: the frame still completes.
- Simultaneous requests: exactly one grant per IDLE cycle. Under full load no requester waits more than N frames.
- Divider counts 0..CLKS_PER_BIT-1; with CLKS_PER_BIT=1 it is constant 0.
- Bit counter is 3 bits and must not wrap into an extra data bit.
- grant is combinational from state/req/pointer, or registered so it still aligns with the capture cycle. Either way, grant and data capture occur in the same cycle.

Decomposition:
- Shared package link_pkg:
  - DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
  - State encoding constants for IDLE/START/DATA/PARITY/STOP, for reuse by the receive side.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req, pointer, enable.
  - Outputs one-hot grant and binary index.
  - Purely combinational; the pointer register lives in the parent.
- Serializer FSM stays in link_tx_arbiter.

Test Plan:
- Reset then idle, no req → tx=1, busy=0, grant=0 for 50 cycles; owner=0.
- N=4, CLKS_PER_BIT=1, req[1]=1 with byte 0xA5 at cycle G:
  - grant=4'b0010 for exactly one cycle.
  - tx from G+1: 0,1,0,1,0,0,1,0,1,1,1 (start, data LSB first, odd parity=1, stop).
  - busy high for 11 cycles; owner=1.
- req=4'b1111 held, bytes 0x00/0x01/0x02/0x03 → grants in order 0,1,2,3,0, consecutive grants 12 cycles apart. Parity bits are 1,0,0,1 with PARITY_ODD=1.
- CLKS_PER_BIT=4, PARITY_ODD=0, byte 0xFF:
  - Every tx bit held 4 cycles; parity bit=0.
  - busy high for 44 cycles; next grant 45 cycles after the first.
- Assert arst at cycle 5 of the data phase → next cycle tx=1, busy=0, state IDLE, pointer 0. A held req[2] alone is re-granted on the cycle after arst deasserts, and the full frame is resent.
- Loopback: tx into the team's receive/decode path with random bytes and requesters for 1000 frames → every out_byte matches the sent byte in grant order, err=0. A bench-injected parity flip produces err=1.

Source files
------------

// File: rtl/link_pkg.sv
// Shared serial-link definitions: frame bit levels, data width and the
// state encoding used by both the transmit arbiter and the receive side.
package link_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] STATE_IDLE   = 3'd0;
    localparam logic [2:0] STATE_START  = 3'd1;
    localparam logic [2:0] STATE_DATA   = 3'd2;
    localparam logic [2:0] STATE_PARITY = 3'd3;
    localparam logic [2:0] STATE_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = STATE_IDLE,
        ST_START  = STATE_START,
        ST_DATA   = STATE_DATA,
        ST_PARITY = STATE_PARITY,
        ST_STOP   = STATE_STOP
    } state_t;

    // Parity bit that makes data+parity odd (odd=1) or even (odd=0).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/link_tx_arbiter_if.sv
// Requester-side bundle of the link transmit arbiter.
// Ports: req/req_data from requesters; grant/tx/busy/owner back from arbiter.
interface link_tx_arbiter_if #(
    parameter int N = 4
);

    logic [N-1:0]         req;
    logic [N*8-1:0]       req_data;
    logic [N-1:0]         grant;
    logic                 tx;
    logic                 busy;
    logic [$clog2(N)-1:0] owner;

    modport master (
        output req,
        output req_data,
        input  grant,
        input  tx,
        input  busy,
        input  owner
    );

    modport slave (
        input  req,
        input  req_data,
        output grant,
        output tx,
        output busy,
        output owner
    );

endinterface

// File: rtl/link_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req at or after pointer.
// Ports: req, pointer, enable in; one-hot grant and binary index out.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] index
);

    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // pointer + i, wrapped back into 0..N-1
            sum = {1'b0, pointer} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            cand = sum[IW-1:0];
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter sharing one serial tx line among N byte requesters.
// Ports: clk, arst (sync, active-high), bus (slave: req/req_data in,
// grant/tx/busy/owner out). Frame: start, 8 data LSB first, parity, stop.
module link_tx_arbiter
    import link_pkg::*;
#(
    parameter int N            = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 1
) (
    input  logic              clk,
    input  logic              arst,
    link_tx_arbiter_if.slave  bus
);

    localparam int IW = $clog2(N);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [2:0]      bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic            tx_q, tx_d;

    logic [N-1:0]    win_grant;
    logic [IW-1:0]   win_idx;
    logic [7:0]      byte_sel;
    logic            arb_en;
    logic            take;
    logic            bit_done;

    // No grant while reset is applied: the capture would be discarded.
    assign arb_en   = (state_q == ST_IDLE) && !arst;
    assign take     = |win_grant;
    assign bit_done = (div_q == DIV_LAST);

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req     (bus.req),
        .pointer (ptr_q),
        .enable  (arb_en),
        .grant   (win_grant),
        .index   (win_idx)
    );

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (win_grant[i]) begin
                byte_sel = byte_sel | bus.req_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            div_q   <= '0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        bit_d   = bit_q;
        div_d   = bit_done ? '0 : div_q + DW'(1);
        tx_d    = IDLE_LEVEL;

        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (take) begin
                    state_d = ST_START;
                    shreg_d = byte_sel;
                    par_d   = parity_bit(byte_sel, PAR_ODD);
                    owner_d = win_idx;
                    if (win_idx == IW'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + IW'(1);
                    end
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shreg_d = shreg_q >> 1;
                    // Leave on the 8th bit; counter never reaches a 9th.
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is registered, so drive the level of the state being entered.
        unique case (state_d)
            ST_IDLE:   tx_d = IDLE_LEVEL;
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = STOP_BIT;
            default:   tx_d = IDLE_LEVEL;
        endcase
    end

    assign bus.grant = win_grant;
    assign bus.tx    = tx_q;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Randomized self-checking bench for link_tx_arbiter with a frame-level
// reference model and a behavioural serial receiver on the tx line.
module tb_link_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           arst;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    bit             sel;
    bit             inject;
    int             cyc = 0;
    int             n_tests = 0;
    int             n_fail = 0;
    int             g_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    link_tx_arbiter_if #(.N(N)) bus_a ();
    link_tx_arbiter_if #(.N(N)) bus_b ();

    assign bus_a.req      = req;
    assign bus_a.req_data = req_data;
    assign bus_b.req      = req;
    assign bus_b.req_data = req_data;

    link_tx_arbiter #(
        .N(N), .CLKS_PER_BIT(1), .PARITY_ODD(1)
    ) dut_a (
        .clk(clk), .arst(arst), .bus(bus_a)
    );

    link_tx_arbiter #(
        .N(N), .CLKS_PER_BIT(4), .PARITY_ODD(0)
    ) dut_b (
        .clk(clk), .arst(arst), .bus(bus_b)
    );

    logic [N-1:0] grant_s;
    logic         tx_s;
    logic         busy_s;
    logic [1:0]   owner_s;

    assign grant_s = sel ? bus_b.grant : bus_a.grant;
    assign tx_s    = sel ? bus_b.tx    : bus_a.tx;
    assign busy_s  = sel ? bus_b.busy  : bus_a.busy;
    assign owner_s = sel ? bus_b.owner : bus_a.owner;

    // Behavioural receiver on dut_a's line (one clock per bit, odd parity).
    int         rx_pos = -1;
    logic [10:0] rx_sh;
    logic [7:0] got_q[$];
    bit         err_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (arst) begin
            rx_pos = -1;
        end else if (rx_pos < 0) begin
            if (bus_a.tx == 1'b0) begin
                rx_sh    = '1;
                rx_sh[0] = 1'b0;
                rx_pos   = 1;
            end
        end else begin
            rx_sh[rx_pos] = bus_a.tx ^ (inject && rx_pos == 9);
            rx_pos++;
            if (rx_pos == 11) begin
                got_q.push_back(rx_sh[8:1]);
                err_q.push_back(!(^rx_sh[9:1]) || !rx_sh[10]);
                rx_pos = -1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
    endtask

    // Expected line levels of one frame, index 0 = start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] b,
                                               input bit odd);
        int   ones;
        logic p;
        ones = $countones(b);
        if (odd) p = (ones % 2) == 0;
        else     p = (ones % 2) == 1;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Waits (bounded) for a grant, then checks the whole frame on tx.
    task automatic run_frame(input int idx, input logic [7:0] b,
                             input bit drop, input int limit);
        int          cpb;
        int          waited;
        bit          odd;
        logic [10:0] f;
        cpb    = sel ? 4 : 1;
        odd    = sel ? 1'b0 : 1'b1;
        waited = 0;
        #1;
        while (grant_s == '0 && waited < limit) begin
            tick();
            #1;
            waited++;
        end
        if (grant_s == '0) begin
            check("grant_wait", 0, 1);
            return;
        end
        g_cyc = cyc;
        check("grant", grant_s, 32'(1) << idx);
        f = frame_bits(b, odd);
        for (int k = 0; k < 11 * cpb; k++) begin
            tick();
            if (drop && k == 0) req[idx] = 1'b0;
            #1;
            check("tx", tx_s, f[k / cpb]);
            check("busy", busy_s, 1);
            check("grant_busy", grant_s, 0);
            if (k == 0) check("owner", owner_s, idx);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         prev;
        int         mp;
        int         w;
        logic [3:0] rv;
        logic [7:0] b;

        sel      = 1'b0;
        inject   = 1'b0;
        arst     = 1'b1;
        req      = '0;
        req_data = '0;
        do_reset();

        // Idle after reset
        #1;
        check("rst_owner", owner_s, 0);
        for (int i = 0; i < 50; i++) begin
            #1;
            check("idle_tx", tx_s, 1);
            check("idle_busy", busy_s, 0);
            check("idle_grant", grant_s, 0);
            tick();
        end

        // Single request, byte 0xA5 on requester 1
        req_data[15:8] = 8'hA5;
        req            = 4'b0010;
        run_frame(1, 8'hA5, 1'b1, 2);
        tick();
        #1;
        check("post_busy", busy_s, 0);
        check("post_tx", tx_s, 1);
        check("post_owner", owner_s, 1);
        check("post_grant", grant_s, 0);

        // Full load from a fresh pointer
        do_reset();
        req_data = {8'h03, 8'h02, 8'h01, 8'h00};
        req      = 4'b1111;
        prev     = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            run_frame(i % 4, 8'(i % 4), 1'b0, 2);
            if (i > 0) check("rr_spacing", g_cyc - prev, 12);
            prev = g_cyc;
        end
        req = '0;

        // Slow bit rate, even parity
        sel = 1'b1;
        do_reset();
        req_data[31:24] = 8'hFF;
        req             = 4'b1000;
        run_frame(3, 8'hFF, 1'b0, 2);
        prev = g_cyc;
        tick();
        #1;
        check("slow_busy_end", busy_s, 0);
        check("slow_regrant", grant_s, 4'b1000);
        check("slow_spacing", cyc - prev, 45);
        req = '0;
        sel = 1'b0;

        // Reset in the middle of the data phase
        do_reset();
        req_data[23:16] = 8'h3C;
        req             = 4'b0100;
        #1;
        check("mid_grant0", grant_s, 4'b0100);
        for (int i = 0; i < 6; i++) tick();
        arst = 1'b1;
        tick();
        arst = 1'b0;
        #1;
        check("mid_tx", tx_s, 1);
        check("mid_busy", busy_s, 0);
        check("mid_owner", owner_s, 0);
        run_frame(2, 8'h3C, 1'b1, 2);
        tick();
        req = 4'b0100;
        #1;
        check("ptr_pre", grant_s, 4'b0100);
        tick();
        req = '0;
        tick();
        tick();
        arst = 1'b1;
        req  = 4'b1010;
        tick();
        arst = 1'b0;
        #1;
        check("ptr_reset", grant_s, 4'b0010);
        req = '0;

        // Loopback through the receiver with random traffic
        do_reset();
        got_q.delete();
        err_q.delete();
        exp_q.delete();
        mp = 0;
        for (int f = 0; f < 1000; f++) begin
            rv       = 4'($urandom_range(1, 15));
            req_data = {$urandom};
            req      = rv;
            w        = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && rv[(mp + i) % N]) w = (mp + i) % N;
            end
            b = req_data[w*8 +: 8];
            exp_q.push_back(b);
            run_frame(w, b, 1'b1, 2);
            mp = (w + 1) % N;
            tick();
        end
        req = '0;
        tick();
        tick();
        check("rx_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("rx_byte", got_q[i], exp_q[i]);
            check("rx_err", err_q[i], 0);
        end

        // Corrupted parity must be flagged
        inject       = 1'b1;
        req_data[7:0] = 8'($urandom);
        req          = 4'b0001;
        run_frame(0, req_data[7:0], 1'b1, 2);
        tick();
        tick();
        inject = 1'b0;
        check("inj_count", got_q.size(), exp_q.size() + 1);
        if (err_q.size() > 0) check("inj_err", err_q[err_q.size()-1], 1);
        else                  check("inj_err", 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
